// File: rtl/wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arb
// Purpose  : Two-master to one-slave Wishbone B4 pipelined arbiter.
//            Round-robin grant held for the whole owner cycle, outstanding
//            transfer tracking, and bus-error abort of hung cycles.
//            Master 0 is the CPU core, master 1 the UART debug/loader bridge.
// Revision : 1.0  initial release
// ============================================================================
module wb_master_arb #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            wb_clk_i,
  input  logic            rst_i,
  // master 0
  input  logic            m0_wb_cyc_i,
  input  logic            m0_wb_stb_i,
  input  logic            m0_wb_we_i,
  input  logic [AW-1:0]   m0_wb_adr_i,
  input  logic [DW-1:0]   m0_wb_dat_i,
  input  logic [DW/8-1:0] m0_wb_sel_i,
  output logic [DW-1:0]   m0_wb_dat_o,
  output logic            m0_wb_ack_o,
  output logic            m0_wb_err_o,
  output logic            m0_wb_stall_o,
  // master 1
  input  logic            m1_wb_cyc_i,
  input  logic            m1_wb_stb_i,
  input  logic            m1_wb_we_i,
  input  logic [AW-1:0]   m1_wb_adr_i,
  input  logic [DW-1:0]   m1_wb_dat_i,
  input  logic [DW/8-1:0] m1_wb_sel_i,
  output logic [DW-1:0]   m1_wb_dat_o,
  output logic            m1_wb_ack_o,
  output logic            m1_wb_err_o,
  output logic            m1_wb_stall_o,
  // slave
  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  output logic            s_wb_we_o,
  output logic [AW-1:0]   s_wb_adr_o,
  output logic [DW-1:0]   s_wb_dat_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_ack_i,
  input  logic            s_wb_err_i,
  input  logic            s_wb_stall_i,
  // debug
  output logic [1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } state_t;

  state_t        state;
  logic          abort_owner;   // master that was aborted (1 = m1)
  logic          last_grant;    // most recent owner (1 = m1)
  logic [OW-1:0] outstanding;
  logic [TW-1:0] timer;

  logic          granted;
  logic          own_is_m1;
  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [SW-1:0] own_sel;
  logic          full;
  logic          resp;
  logic          timeout_fire;
  logic          accept;

  // Select the current owner's request signals from the registered state
  always_comb begin
    granted   = (state == GRANT0) || (state == GRANT1);
    own_is_m1 = (state == ABORT) ? abort_owner : (state == GRANT1);
    own_cyc   = own_is_m1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    own_stb   = own_is_m1 ? m1_wb_stb_i : m0_wb_stb_i;
    own_we    = own_is_m1 ? m1_wb_we_i  : m0_wb_we_i;
    own_adr   = own_is_m1 ? m1_wb_adr_i : m0_wb_adr_i;
    own_dat   = own_is_m1 ? m1_wb_dat_i : m0_wb_dat_i;
    own_sel   = own_is_m1 ? m1_wb_sel_i : m0_wb_sel_i;
    full      = (outstanding == OUT_MAX);
    resp      = s_wb_ack_i | s_wb_err_i;
    // A slave response in the last timer cycle, or the owner releasing,
    // both pre-empt the abort.
    timeout_fire = granted && own_cyc && (outstanding != '0) &&
                   (timer == TIMER_LAST) && !resp;
  end

  // Route the owner onto the slave port; strobe is held off while full
  always_comb begin
    s_wb_cyc_o = granted && own_cyc && !timeout_fire;
    s_wb_stb_o = s_wb_cyc_o && own_stb && !full;
    s_wb_we_o  = granted ? own_we  : 1'b0;
    s_wb_adr_o = granted ? own_adr : '0;
    s_wb_dat_o = granted ? own_dat : '0;
    s_wb_sel_o = granted ? own_sel : '0;
    accept     = s_wb_stb_o && !s_wb_stall_i;
  end

  // Return path: only the owner sees slave responses, everyone else stalls
  always_comb begin
    m0_wb_dat_o   = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    if (granted && !own_is_m1) begin
      m0_wb_dat_o   = s_wb_dat_i;
      m0_wb_ack_o   = s_wb_ack_i;
      m0_wb_err_o   = s_wb_err_i | timeout_fire;
      m0_wb_stall_o = s_wb_stall_i | full | timeout_fire;
    end
    if (granted && own_is_m1) begin
      m1_wb_dat_o   = s_wb_dat_i;
      m1_wb_ack_o   = s_wb_ack_i;
      m1_wb_err_o   = s_wb_err_i | timeout_fire;
      m1_wb_stall_o = s_wb_stall_i | full | timeout_fire;
    end
  end

  // Arbitration FSM with outstanding counter and hang timer
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      grant_o     <= 2'b00;
      abort_owner <= 1'b0;
      last_grant  <= 1'b1;
      outstanding <= '0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= '0;
          timer       <= '0;
          if (m0_wb_cyc_i && m1_wb_cyc_i) begin
            if (last_grant) begin
              state   <= GRANT0;
              grant_o <= 2'b01;
            end else begin
              state   <= GRANT1;
              grant_o <= 2'b10;
            end
          end else if (m0_wb_cyc_i) begin
            state   <= GRANT0;
            grant_o <= 2'b01;
          end else if (m1_wb_cyc_i) begin
            state   <= GRANT1;
            grant_o <= 2'b10;
          end
        end

        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            // Owner released: abandon anything still in flight
            state       <= IDLE;
            grant_o     <= 2'b00;
            last_grant  <= own_is_m1;
            outstanding <= '0;
            timer       <= '0;
          end else if (timeout_fire) begin
            state       <= ABORT;
            grant_o     <= 2'b00;
            abort_owner <= own_is_m1;
            outstanding <= '0;
            timer       <= '0;
          end else begin
            if (accept && !(resp && outstanding != '0)) begin
              outstanding <= outstanding + 1'b1;
            end else if (!accept && resp && outstanding != '0) begin
              outstanding <= outstanding - 1'b1;
            end
            if (outstanding == '0 || resp) begin
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        ABORT: begin
          outstanding <= '0;
          timer       <= '0;
          if (!own_cyc) begin
            state      <= IDLE;
            last_grant <= abort_owner;
          end
        end

        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arb
// Purpose  : Directed self-checking bench for wb_master_arb.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_master_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_dat = '0;
  logic [3:0]    m0_sel = '0;
  logic [DW-1:0] m0_rdat;
  logic          m0_ack, m0_err, m0_stall;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_dat = '0;
  logic [3:0]    m1_sel = '0;
  logic [DW-1:0] m1_rdat;
  logic          m1_ack, m1_err, m1_stall;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [3:0]    s_sel;
  logic [DW-1:0] s_rdat = '0;
  logic          s_ack = 0, s_err = 0, s_stall = 0;
  logic [1:0]    grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_master_arb #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO), .MAX_OUTSTANDING(MO)
  ) dut (
    .wb_clk_i(clk), .rst_i(rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m0_wb_stall_o(m0_stall),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .m1_wb_stall_o(m1_stall),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .s_wb_stall_i(s_stall),
    .grant_o(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick(); settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_err", m1_err, 0);
    tick(); rst = 1'b1;

    // ---------------- single m0 read ----------------
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0100_0000; m0_sel = 4'hF;
    settle();
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_s_cyc", s_cyc, 0);
    chk("t1_idle_m0_stall", m0_stall, 1);
    tick(); settle();
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_adr", s_adr, 32'h0100_0000);
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_s_stb", s_stb, 1);
    chk("t1_m0_stall", m0_stall, 0);
    chk("t1_m1_stall", m1_stall, 1);
    tick(); m0_stb = 0; s_ack = 1; s_rdat = 32'hDEAD_BEEF; settle();
    chk("t1_m0_dat", m0_rdat, 32'hDEAD_BEEF);
    chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m1_ack", m1_ack, 0);
    chk("t1_m1_dat", m1_rdat, 0);
    chk("t1_m1_stall_ack", m1_stall, 1);
    tick(); s_ack = 0; s_rdat = 0; m0_cyc = 0; settle();
    chk("t1_rel_s_cyc", s_cyc, 0);
    chk("t1_rel_grant", grant, 2'b01);
    tick(); settle();
    chk("t1_idle_after", grant, 2'b00);

    // reset pulse so arbitration history returns to its reset value
    tick(); rst = 0; settle();
    tick(); rst = 1;

    // ---------------- round robin ----------------
    tick(); m0_cyc = 1; m1_cyc = 1; settle();
    chk("t2_req_grant", grant, 2'b00);
    tick(); settle();
    chk("t2_first_m0", grant, 2'b01);
    chk("t2_m1_stall", m1_stall, 1);
    tick(); m0_cyc = 0; settle();
    chk("t2_m0_rel_cyc", s_cyc, 0);
    tick(); settle();
    chk("t2_gap_idle", grant, 2'b00);
    tick(); settle();
    chk("t2_second_m1", grant, 2'b10);
    chk("t2_m0_stall", m0_stall, 1);
    chk("t2_m1_cyc_routed", s_cyc, 1);
    tick(); m1_cyc = 0; m0_cyc = 1; settle();
    tick(); m1_cyc = 1; settle();
    chk("t2_gap2_idle", grant, 2'b00);
    tick(); settle();
    chk("t2_third_m0", grant, 2'b01);
    tick(); m0_cyc = 0; m1_cyc = 0; settle();
    tick(); settle();

    // ---------------- outstanding limit ----------------
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h2000_0010;
    m1_dat = 32'hA5A5_0001; m1_sel = 4'hF;
    settle();
    tick(); settle();
    chk("t3_grant", grant, 2'b10);
    chk("t3_s_we", s_we, 1);
    chk("t3_s_adr", s_adr, 32'h2000_0010);
    chk("t3_s_dat", s_wdat, 32'hA5A5_0001);
    chk("t3_stb1", s_stb, 1);
    tick(); settle();
    chk("t3_stb2", s_stb, 1);
    tick(); settle();
    chk("t3_stb3", s_stb, 1);
    tick(); settle();
    chk("t3_stb4", s_stb, 1);
    chk("t3_stall4", m1_stall, 0);
    tick(); settle();
    chk("t3_full_stb", s_stb, 0);
    chk("t3_full_stall", m1_stall, 1);
    chk("t3_full_cyc", s_cyc, 1);
    tick(); s_ack = 1; settle();
    chk("t3_ack", m1_ack, 1);
    chk("t3_ack_stb", s_stb, 0);
    tick(); s_ack = 0; settle();
    chk("t3_stb5", s_stb, 1);
    chk("t3_stall5", m1_stall, 0);
    tick(); settle();
    chk("t3_refull_stb", s_stb, 0);
    chk("t3_refull_stall", m1_stall, 1);
    m1_cyc = 0; m1_stb = 0; settle();
    chk("t3_rel_cyc", s_cyc, 0);
    tick(); settle();
    chk("t3_idle", grant, 2'b00);

    // ---------------- timeout abort ----------------
    tick(); m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0040; settle();
    tick(); m1_cyc = 1; settle();
    chk("t4_grant", grant, 2'b01);
    chk("t4_accept", s_stb, 1);
    for (int k = 1; k <= TO - 1; k++) begin
      tick(); m0_stb = 0; settle();
      chk("t4_no_err_yet", m0_err, 0);
    end
    tick(); settle();
    chk("t4_err", m0_err, 1);
    chk("t4_err_cyc", s_cyc, 0);
    chk("t4_err_ack", m0_ack, 0);
    tick(); settle();
    chk("t4_abort_grant", grant, 2'b00);
    chk("t4_abort_cyc", s_cyc, 0);
    chk("t4_abort_err", m0_err, 0);
    chk("t4_abort_stall", m0_stall, 1);
    tick(); settle();
    chk("t4_abort_hold", grant, 2'b00);
    chk("t4_abort_m1_stall", m1_stall, 1);
    m0_cyc = 0;
    tick(); settle();
    chk("t4_idle", grant, 2'b00);
    tick(); settle();
    chk("t4_m1_next", grant, 2'b10);
    tick(); m1_cyc = 0; settle();
    tick(); settle();

    // ---------------- ack in the timeout cycle ----------------
    tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0080; settle();
    tick(); settle();
    chk("t5_grant", grant, 2'b01);
    for (int k = 1; k <= TO - 1; k++) begin
      tick(); m0_stb = 0; settle();
    end
    tick(); s_ack = 1; s_rdat = 32'h1234_5678; settle();
    chk("t5_ack", m0_ack, 1);
    chk("t5_no_err", m0_err, 0);
    chk("t5_cyc", s_cyc, 1);
    chk("t5_dat", m0_rdat, 32'h1234_5678);
    tick(); s_ack = 0; s_rdat = 0; settle();
    chk("t5_kept", grant, 2'b01);
    chk("t5_kept_cyc", s_cyc, 1);
    chk("t5_kept_err", m0_err, 0);

    // ---------------- release in the timeout cycle ----------------
    m0_stb = 1; settle();
    tick(); m0_stb = 0; settle();
    for (int k = 1; k <= TO - 2; k++) begin
      tick(); settle();
    end
    tick(); m0_cyc = 0; settle();
    chk("t5b_no_err", m0_err, 0);
    chk("t5b_cyc", s_cyc, 0);
    tick(); settle();
    chk("t5b_idle", grant, 2'b00);

    // ---------------- asynchronous reset mid-transfer ----------------
    tick(); m1_cyc = 1; m1_stb = 1; m1_we = 1; settle();
    tick(); settle();
    chk("t6_grant", grant, 2'b10);
    tick(); settle();
    tick(); m1_stb = 0; settle();
    chk("t6_pre_cyc", s_cyc, 1);
    rst = 0; settle();
    chk("t6_rst_cyc", s_cyc, 0);
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_m0_stall", m0_stall, 1);
    chk("t6_rst_m1_stall", m1_stall, 1);
    tick(); settle();
    tick(); rst = 1; m1_stb = 1; settle();
    chk("t6_rel_grant", grant, 2'b00);
    tick(); settle();
    chk("t6_regrant", grant, 2'b10);
    chk("t6_stb1", s_stb, 1);
    tick(); settle();
    chk("t6_stb2", s_stb, 1);
    tick(); settle();
    chk("t6_stb3", s_stb, 1);
    tick(); settle();
    chk("t6_stb4", s_stb, 1);
    tick(); settle();
    chk("t6_full_stb", s_stb, 0);
    chk("t6_full_stall", m1_stall, 1);
    m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
